// File: rtl/reset_sequencer.sv
// ============================================================================
//  Module   : reset_sequencer
//  Brief    : Staged reset release/assertion sequencer. Stages are released
//             in ascending order, each after a fixed delay and gated on the
//             previous stage's acknowledge (with an optional timeout), and
//             re-asserted in descending order, one stage per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_sequencer #(
    parameter int NUM_STAGES     = 3,
    parameter int STAGE_DELAY_CC = 50000,
    parameter int ACK_TIMEOUT_CC = 100000
) (
    input  logic                  piul1Clock,
    input  logic                  piul1Reset,
    input  logic                  piul1ResetReq,
    input  logic [NUM_STAGES-1:0] pivul1StageAck,
    output logic [NUM_STAGES-1:0] poulvStageReset,
    output logic                  poul1SysReady,
    output logic                  poul1AckTimeout
);

    // The counter must reach both the release delay and the ack timeout.
    localparam int c_CNT_SPAN = (STAGE_DELAY_CC > ACK_TIMEOUT_CC) ? STAGE_DELAY_CC : ACK_TIMEOUT_CC;
    localparam int c_CNT_W    = $clog2(c_CNT_SPAN + 1);
    localparam int c_IDX_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [c_CNT_W-1:0] c_DELAY_LAST   = c_CNT_W'(STAGE_DELAY_CC - 1);
    // When the timeout is disabled this value is never compared.
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(ACK_TIMEOUT_CC - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX     = c_IDX_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        S_HOLD     = 3'd0,
        S_RELEASE  = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_READY    = 3'd3,
        S_ASSERT   = 3'd4
    } state_t;

    state_t                r_state;
    logic [c_IDX_W-1:0]    r_idx;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [NUM_STAGES-1:0] r_stage;
    logic                  r_ready;
    logic                  r_timeout;

    state_t                w_state_nxt;
    logic [c_IDX_W-1:0]    w_idx_nxt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic [NUM_STAGES-1:0] w_stage_nxt;
    logic                  w_ready_nxt;
    logic                  w_timeout_nxt;
    logic                  w_advance;
    logic [c_CNT_W-1:0]    w_cnt_inc;
    logic [c_IDX_W-1:0]    w_top_zero;

    // Saturating increment: a disabled ack timeout may count indefinitely.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    // Locate the highest released stage; with a thermometer-shaped vector
    // this is the next stage to re-assert.
    always_comb begin
        w_top_zero = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (!r_stage[i]) begin
                w_top_zero = c_IDX_W'(i);
            end
        end
    end

    // State register and sequencing datapath.
    always_ff @(posedge piul1Clock or posedge piul1Reset) begin
        if (piul1Reset) begin
            r_state   <= S_HOLD;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_stage   <= '1;
            r_ready   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_stage   <= w_stage_nxt;
            r_ready   <= w_ready_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Next-state logic; a reset request overrides everything outside HOLD/ASSERT.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_stage_nxt   = r_stage;
        w_ready_nxt   = r_ready;
        w_timeout_nxt = r_timeout;
        w_advance     = 1'b0;

        case (r_state)
            S_HOLD: begin
                if (!piul1ResetReq) begin
                    w_state_nxt   = S_RELEASE;
                    w_idx_nxt     = '0;
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = 1'b0;
                end
            end
            S_RELEASE: begin
                if (piul1ResetReq) begin
                    w_state_nxt = S_ASSERT;
                    w_ready_nxt = 1'b0;
                end else if (r_cnt == c_DELAY_LAST) begin
                    w_stage_nxt[r_idx] = 1'b0;
                    w_cnt_nxt          = '0;
                    w_state_nxt        = S_WAIT_ACK;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_WAIT_ACK: begin
                if (piul1ResetReq) begin
                    w_state_nxt = S_ASSERT;
                    w_ready_nxt = 1'b0;
                end else if (pivul1StageAck[r_idx]) begin
                    w_advance = 1'b1;
                end else if ((ACK_TIMEOUT_CC != 0) && (r_cnt == c_TIMEOUT_LAST)) begin
                    w_timeout_nxt = 1'b1;
                    w_advance     = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_READY: begin
                if (piul1ResetReq) begin
                    w_state_nxt = S_ASSERT;
                    w_ready_nxt = 1'b0;
                end
            end
            S_ASSERT: begin
                if (&r_stage) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_stage_nxt[w_top_zero] = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_HOLD;
            end
        endcase

        // Move on to the next stage, or finish the sequence.
        if (w_advance) begin
            if (r_idx == c_LAST_IDX) begin
                w_state_nxt = S_READY;
                w_ready_nxt = 1'b1;
            end else begin
                w_idx_nxt   = r_idx + 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_RELEASE;
            end
        end
    end

    assign poulvStageReset = r_stage;
    assign poul1SysReady   = r_ready;
    assign poul1AckTimeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
//  Module   : tb_reset_sequencer
//  Brief    : Self-checking bench for reset_sequencer (3 stages, delay 4,
//             ack timeout 8): timing vectors, multi-cycle corner sequences
//             and randomized traffic against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

    localparam int NS  = 3;
    localparam int DLY = 4;
    localparam int TO  = 8;

    logic          clk;
    logic          rst;
    logic          req;
    logic [NS-1:0] ack;
    logic [NS-1:0] stage;
    logic          ready;
    logic          tmo;

    int checks;
    int errors;

    reset_sequencer #(
        .NUM_STAGES     (NS),
        .STAGE_DELAY_CC (DLY),
        .ACK_TIMEOUT_CC (TO)
    ) dut (
        .piul1Clock      (clk),
        .piul1Reset      (rst),
        .piul1ResetReq   (req),
        .pivul1StageAck  (ack),
        .poulvStageReset (stage),
        .poul1SysReady   (ready),
        .poul1AckTimeout (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NS-1:0] ack;
        int            edge_n;
        logic [NS-1:0] stage;
        logic          ready;
        logic          tmo;
    } vec_t;

    vec_t tbl[$];

    // ---------------- behavioural model ----------------
    // Tracks how many stages are released (thermometer count) and the
    // elapsed time in the current activity, with an unbounded timer.
    localparam int M_IDLE = 0, M_DELAY = 1, M_ACK = 2, M_DONE = 3, M_DOWN = 4;
    int m_mode, m_rel, m_cur, m_t;
    bit m_rdy, m_to;

    function automatic void model_reset();
        m_mode = M_IDLE; m_rel = 0; m_cur = 0; m_t = 0; m_rdy = 0; m_to = 0;
    endfunction

    function automatic logic [NS-1:0] model_vec();
        logic [NS-1:0] v;
        v = '1;
        for (int i = 0; i < NS; i++) if (i < m_rel) v[i] = 1'b0;
        return v;
    endfunction

    function automatic void model_next_stage();
        if (m_cur == NS - 1) begin
            m_mode = M_DONE; m_rdy = 1;
        end else begin
            m_cur++; m_t = 0; m_mode = M_DELAY;
        end
    endfunction

    function automatic void model_step(input logic r, input logic [NS-1:0] a);
        if (r && (m_mode == M_DELAY || m_mode == M_ACK || m_mode == M_DONE)) begin
            m_mode = M_DOWN; m_rdy = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (!r) begin m_mode = M_DELAY; m_cur = 0; m_t = 0; m_to = 0; end
                M_DELAY: begin
                    m_t++;
                    if (m_t == DLY) begin m_rel = m_cur + 1; m_t = 0; m_mode = M_ACK; end
                end
                M_ACK: begin
                    if (a[m_cur]) model_next_stage();
                    else if (m_t == TO - 1) begin m_to = 1; model_next_stage(); end
                    else m_t++;
                end
                M_DOWN: if (m_rel == 0) m_mode = M_IDLE; else m_rel--;
                default: ;
            endcase
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [NS-1:0] es, input logic er, input logic et);
        checks++;
        if (stage !== es || ready !== er || tmo !== et) begin
            errors++;
            $display("FAIL %s: got stage=%b ready=%b timeout=%b, expected stage=%b ready=%b timeout=%b",
                     name, stage, ready, tmo, es, er, et);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Reset pulse placed between clock edges; outputs must react at once.
    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("async_reset", '1, 1'b0, 1'b0);
        #1 rst = 1'b0;
    endtask

    function automatic void add(input logic [NS-1:0] a, input int e, input logic [NS-1:0] s,
                                input logic r, input logic t);
        vec_t v;
        v.ack = a; v.edge_n = e; v.stage = s; v.ready = r; v.tmo = t;
        tbl.push_back(v);
    endfunction

    initial begin
        int e;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        req = 1'b1;
        ack = '0;
        #2 check("reset_state", '1, 1'b0, 1'b0);
        #1 rst = 1'b0;

        // All acks high: releases at E4/E9/E14, ready at E15.
        add(3'b111,  3, 3'b111, 0, 0);
        add(3'b111,  4, 3'b110, 0, 0);
        add(3'b111,  8, 3'b110, 0, 0);
        add(3'b111,  9, 3'b100, 0, 0);
        add(3'b111, 13, 3'b100, 0, 0);
        add(3'b111, 14, 3'b000, 0, 0);
        add(3'b111, 15, 3'b000, 1, 0);
        // Stage 1 never acks: timeout at E17, stage 2 at E21, ready at E22.
        add(3'b101,  9, 3'b100, 0, 0);
        add(3'b101, 16, 3'b100, 0, 0);
        add(3'b101, 17, 3'b100, 0, 1);
        add(3'b101, 20, 3'b100, 0, 1);
        add(3'b101, 21, 3'b000, 0, 1);
        add(3'b101, 22, 3'b000, 1, 1);

        e = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            if (i == 0 || tbl[i].ack != tbl[i-1].ack || tbl[i].edge_n <= e) begin
                ack = tbl[i].ack;
                req = 1'b1;
                do_reset();
                req = 1'b0;
                e = -1;
            end
            while (e < tbl[i].edge_n) begin
                tick();
                e++;
            end
            check($sformatf("vec%0d_E%0d", i, tbl[i].edge_n), tbl[i].stage, tbl[i].ready, tbl[i].tmo);
        end

        // Request during READY with timeout flagged; a low pulse during ASSERT is ignored.
        req = 1'b1; tick(); check("t5_F0_ready_drop", 3'b000, 0, 1);
        req = 1'b0; tick(); check("t5_F1_stage2_up", 3'b100, 0, 1);
        req = 1'b1; tick(); check("t5_F2_stage1_up", 3'b110, 0, 1);
        tick();             check("t5_F3_stage0_up", 3'b111, 0, 1);
        tick();             check("t5_F4_hold", 3'b111, 0, 1);
        tick();             check("t5_F5_hold_stays", 3'b111, 0, 1);
        // Fresh sequence clears the timeout and restarts with the full delay.
        ack = 3'b111;
        req = 1'b0; tick(); check("t5_G0_to_cleared", 3'b111, 0, 0);
        ticks(3);           check("t5_G3_still_held", 3'b111, 0, 0);
        tick();             check("t5_G4_stage0_rel", 3'b110, 0, 0);
        ticks(10);          check("t5_G14_all_rel", 3'b000, 0, 0);
        tick();             check("t5_G15_ready", 3'b000, 1, 0);

        // Descending re-assertion from READY.
        req = 1'b1; tick(); check("t3_F0", 3'b000, 0, 0);
        tick();             check("t3_F1", 3'b100, 0, 0);
        tick();             check("t3_F2", 3'b110, 0, 0);
        tick();             check("t3_F3", 3'b111, 0, 0);
        tick();             check("t3_F4", 3'b111, 0, 0);

        // Request while stage 1 is in its release delay.
        req = 1'b0; ticks(5); check("t4_H4_stage0_rel", 3'b110, 0, 0);
        tick();               check("t4_H5_ack0", 3'b110, 0, 0);
        req = 1'b1; tick();   check("t4_H6_req", 3'b110, 0, 0);
        tick();               check("t4_H7_stage0_up", 3'b111, 0, 0);
        tick();               check("t4_H8_hold", 3'b111, 0, 0);
        req = 1'b0; ticks(4); check("t4_E3_held", 3'b111, 0, 0);
        tick();               check("t4_E4_stage0_rel", 3'b110, 0, 0);

        // Async reset during WAIT_ACK for stage 1, then restart from stage 0.
        req = 1'b1; ticks(3);
        req = 1'b0; ack = 3'b101;
        ticks(11);            check("t6_E10_wait_ack", 3'b100, 0, 0);
        do_reset();
        ticks(4);             check("t6_E3_held", 3'b111, 0, 0);
        tick();               check("t6_E4_stage0_rel", 3'b110, 0, 0);

        // Randomized traffic against the model.
        req = 1'b1;
        do_reset();
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                model_reset();
            end
            if ($urandom_range(0, 39) == 0) req = ~req;
            for (int b = 0; b < NS; b++) ack[b] = ($urandom_range(0, 5) == 0);
            model_step(req, ack);
            tick();
            check($sformatf("rand_%0d", n), model_vec(), m_rdy, m_to);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
